neuron_layer_seq: RTL
=====================

// Module: neuron_layer_seq
// PURPOSE
//  Layer sequencer that drives the neuron MAC core stream (start/data/weight/xw_val/xw_last/bias_acc).
//  Reads input vector, weights and biases from 1-cycle-latency SRAMs and streams n_in beats per neuron.
//  Captures each neuron result on nc_done and writes it to an output buffer.
//  One run covers a full dense layer of n_out neurons.
// PARAMETERS
//  N          16   data/weight/result width (signed)
//  ACC_WIDTH  40   bias/accumulator width
//  MAX_IN     32   max inputs per neuron;  IN_AW  = $clog2(MAX_IN)
//  MAX_OUT    16   max neurons per layer;  OUT_AW = $clog2(MAX_OUT); W_AW = IN_AW+OUT_AW
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          async active-low reset
//  run_i         in   1          1-cycle pulse, starts a layer; ignored while busy_o=1
//  cfg_n_in      in   IN_AW+1    inputs per neuron, latched on accepted run_i
//  cfg_n_out     in   OUT_AW+1   neurons in layer, latched on accepted run_i
//  cfg_act_sel   in   2          activation code (0 linear, 1 ReLU), latched
//  busy_o        out  1          high from the cycle after an accepted run_i until done_o
//  done_o        out  1          1-cycle pulse at end of run
//  err_o         out  1          1-cycle pulse with done_o when the config is illegal
//  x_re/x_addr   out  1/IN_AW    input-vector read; x_rdata in N, valid the next cycle
//  w_re/w_addr   out  1/W_AW     weight read; w_rdata in N, valid the next cycle
//  b_re/b_addr   out  1/OUT_AW   bias read; b_rdata in ACC_WIDTH, valid the next cycle
//  nc_start, nc_xw_val, nc_xw_last  out 1    MAC core control
//  nc_data, nc_weight      out  N           = x_rdata, w_rdata (pass-through)
//  nc_bias_acc             out  ACC_WIDTH   = b_rdata
//  nc_act_sel              out  2           latched cfg_act_sel
//  nc_out / nc_done        in   N / 1       MAC core result and done
//  y_we/y_addr/y_data      out  1/OUT_AW/N  result write port
//  perf_cycles_o           out  32          see CONFIGURATION
// BEHAVIOUR
//  Reset: state IDLE; every control/strobe output 0; busy_o=0; addresses 0; counters 0; nc_act_sel=0.
//  Error check on run_i: cfg_n_in==0, cfg_n_out==0, cfg_n_in>MAX_IN or cfg_n_out>MAX_OUT
//    -> err_o and done_o pulse in cycle 1; no memory or MAC traffic; no y writes.
//  FSM states and transitions:
//   IDLE  -> ISSUE on a legal run_i
//   ISSUE: one read per cycle for n_in cycles; x_addr=i, w_addr=running pointer; b_re only on i=0
//   WAIT  -> entered after the last issue; stays until nc_done=1
//   WAIT  -> ISSUE (next neuron) on nc_done, or -> IDLE after the final neuron
//  Weight pointer: starts at 0 on run; +1 per issue; not reset between neurons (row-major j*n_in+i).
//  Beat flags are registered 1 cycle after the issue so they line up with the SRAM data:
//   nc_xw_val=1 on every beat; nc_start=1 on beat 0; nc_xw_last=1 on beat n_in-1.
//  n_in=1: nc_start and nc_xw_last are high on the same beat.
//  Outputs driven outside beats: nc_xw_val=0; nc_start=0; nc_xw_last=0.
//  nc_done cycle: y_data<=nc_out, y_addr<=j, y_we pulses next cycle; the next neuron issues in that same cycle.
//  Timing: period per neuron = n_in+2 cycles. run_i at cycle 0 -> first issue at cycle 1.
//   Final y_we, done_o and busy_o fall all occur at cycle 1+n_out*(n_in+2).
//  An nc_done outside WAIT is ignored. run_i while busy is dropped, with no effect on the latched cfg.
//  Reset mid-run: immediate return to IDLE; no y write; no done_o.
// CONFIGURATION
//  NEURON_LAYER_SEQ_PERF_EN defined:
//   perf_cycles_o clears on an accepted run_i and counts +1 per cycle while busy_o=1.
//   It holds its value after done_o and saturates at 2^32-1.
//  Not defined: perf_cycles_o tied to 0 and the counter is not built.
// STRUCTURE
//  neuron_pkg: ACT_LINEAR=2'd0, ACT_RELU=2'd1; seq_state_t enum {IDLE,ISSUE,WAIT}; beat-flag struct.
//  Sub-module neuron_layer_addr_gen: input index i, neuron index j, weight-pointer counters, last-issue/last-neuron flags.
//  FSM and beat-flag pipeline stay in the top module.
// TESTING
//  n_in=4, n_out=2, x={1,2,3,4}, w row0={1,1,1,1}, row1={2,0,0,0}, b={0,5}
//   -> y[0]=10, y[1]=7; done_o at cycle 13.
//  n_in=1, n_out=3 -> nc_start and nc_xw_last coincide on each beat; 3 y writes at 3-cycle spacing.
//  ReLU: act_sel=1, b=-100, x*w sum=10 -> nc_act_sel=1; y=0 as returned by the core.
//  cfg_n_in=0 (and separately cfg_n_out=MAX_OUT+1) -> err_o and done_o at cycle 1; no x_re/w_re/y_we.
//  run_i pulsed during busy and rst_n dropped mid-ISSUE -> no restart; after reset all outputs 0, state IDLE.
//  PERF_EN build, n_in=4, n_out=2 -> perf_cycles_o=12 after done_o; non-PERF build -> 0.

Source files
------------

// File: rtl/neuron_layer_seq_pkg.sv
// Shared types for the dense-layer sequencer: activation codes,
// FSM state encoding and the per-beat MAC control bundle.
package neuron_layer_seq_pkg;

    localparam logic [1:0] ACT_LINEAR = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } seq_state_t;

    // Control flags that travel with one x/w data beat.
    typedef struct packed {
        logic start;
        logic val;
        logic last;
    } beat_t;

    localparam beat_t BEAT_NONE = '0;

endpackage

// File: rtl/neuron_layer_seq_if.sv
// Memory, MAC-core and result-buffer bus of the layer sequencer.
// master: sequencer side; slave: SRAMs / MAC core / output buffer.
interface neuron_layer_seq_if #(
    parameter int N         = 16,
    parameter int ACC_WIDTH = 40,
    parameter int IN_AW     = 5,
    parameter int OUT_AW    = 4,
    parameter int W_AW      = 9
);
    logic                        x_re;
    logic [IN_AW-1:0]            x_addr;
    logic signed [N-1:0]         x_rdata;
    logic                        w_re;
    logic [W_AW-1:0]             w_addr;
    logic signed [N-1:0]         w_rdata;
    logic                        b_re;
    logic [OUT_AW-1:0]           b_addr;
    logic signed [ACC_WIDTH-1:0] b_rdata;

    logic                        nc_start;
    logic                        nc_xw_val;
    logic                        nc_xw_last;
    logic signed [N-1:0]         nc_data;
    logic signed [N-1:0]         nc_weight;
    logic signed [ACC_WIDTH-1:0] nc_bias_acc;
    logic [1:0]                  nc_act_sel;
    logic signed [N-1:0]         nc_out;
    logic                        nc_done;

    logic                        y_we;
    logic [OUT_AW-1:0]           y_addr;
    logic signed [N-1:0]         y_data;

    modport master (
        output x_re, x_addr, w_re, w_addr, b_re, b_addr,
        input  x_rdata, w_rdata, b_rdata,
        output nc_start, nc_xw_val, nc_xw_last,
        output nc_data, nc_weight, nc_bias_acc, nc_act_sel,
        input  nc_out, nc_done,
        output y_we, y_addr, y_data
    );

    modport slave (
        input  x_re, x_addr, w_re, w_addr, b_re, b_addr,
        output x_rdata, w_rdata, b_rdata,
        input  nc_start, nc_xw_val, nc_xw_last,
        input  nc_data, nc_weight, nc_bias_acc, nc_act_sel,
        output nc_out, nc_done,
        input  y_we, y_addr, y_data
    );

endinterface

// File: rtl/neuron_layer_seq_addr_gen.sv
// Address counters for the layer sequencer: input index i, neuron j,
// running row-major weight pointer, plus last-issue/last-neuron flags.
// Ports: clr_i restarts a run, step_i marks one issue, nrn_i advances j.
module neuron_layer_addr_gen #(
    parameter int IN_AW  = 5,
    parameter int OUT_AW = 4,
    parameter int W_AW   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic              nrn_i,
    input  logic [IN_AW:0]    n_in_i,
    input  logic [OUT_AW:0]   n_out_i,
    output logic [IN_AW-1:0]  i_o,
    output logic [OUT_AW-1:0] j_o,
    output logic [W_AW-1:0]   w_o,
    output logic              last_issue_o,
    output logic              last_nrn_o
);

    logic [IN_AW-1:0]  i_q, i_d;
    logic [OUT_AW-1:0] j_q, j_d;
    logic [W_AW-1:0]   w_q, w_d;

    assign last_issue_o = ({1'b0, i_q} == n_in_i - 1'b1);
    assign last_nrn_o   = ({1'b0, j_q} == n_out_i - 1'b1);

    // The weight pointer never rewinds between neurons, so after the
    // last issue of row j it already points at row j+1.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        w_d = w_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            w_d = '0;
        end else begin
            if (step_i) begin
                w_d = w_q + 1'b1;
                i_d = last_issue_o ? '0 : i_q + 1'b1;
            end
            if (nrn_i) begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            w_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            w_q <= w_d;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;
    assign w_o = w_q;

endmodule

// File: rtl/neuron_layer_seq.sv
// Dense-layer sequencer: streams x/w/bias beats into the MAC core per
// neuron and writes each result to the output buffer.
// Ports: run_i/cfg_* start a run; busy_o/done_o/err_o report status;
// bus (master) carries SRAM reads, MAC stream and y writes;
// perf_cycles_o counts busy cycles when NEURON_LAYER_SEQ_PERF_EN is
// defined, otherwise it is tied to 0.
module neuron_layer_seq
    import neuron_layer_seq_pkg::*;
#(
    parameter int N         = 16,
    parameter int ACC_WIDTH = 40,
    parameter int MAX_IN    = 32,
    parameter int MAX_OUT   = 16,
    localparam int IN_AW    = $clog2(MAX_IN),
    localparam int OUT_AW   = $clog2(MAX_OUT),
    localparam int W_AW     = IN_AW + OUT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [IN_AW:0]    cfg_n_in,
    input  logic [OUT_AW:0]   cfg_n_out,
    input  logic [1:0]        cfg_act_sel,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       perf_cycles_o,
    neuron_layer_seq_if.master bus
);

    localparam logic [IN_AW:0]  MAX_IN_C  = (IN_AW + 1)'(MAX_IN);
    localparam logic [OUT_AW:0] MAX_OUT_C = (OUT_AW + 1)'(MAX_OUT);

    seq_state_t          state_q;
    logic [IN_AW:0]      n_in_q;
    logic [OUT_AW:0]     n_out_q;
    logic [1:0]          act_q;
    logic                re_q;
    logic                b_re_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    beat_t               beat_q;
    logic                y_we_q;
    logic [OUT_AW-1:0]   y_addr_q;
    logic signed [N-1:0] y_data_q;

    logic [IN_AW-1:0]    i_w;
    logic [OUT_AW-1:0]   j_w;
    logic [W_AW-1:0]     w_w;
    logic                last_issue;
    logic                last_nrn;
    logic                cfg_bad;
    logic                start_run;
    logic                step;
    logic                nrn_adv;

    assign cfg_bad = (cfg_n_in == '0) || (cfg_n_out == '0) ||
                     (cfg_n_in > MAX_IN_C) || (cfg_n_out > MAX_OUT_C);

    assign start_run = (state_q == IDLE) && run_i && !cfg_bad;
    assign step      = (state_q == ISSUE);
    assign nrn_adv   = (state_q == WAIT) && bus.nc_done && !last_nrn;

    neuron_layer_addr_gen #(
        .IN_AW  (IN_AW),
        .OUT_AW (OUT_AW),
        .W_AW   (W_AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (start_run),
        .step_i       (step),
        .nrn_i        (nrn_adv),
        .n_in_i       (n_in_q),
        .n_out_i      (n_out_q),
        .i_o          (i_w),
        .j_o          (j_w),
        .w_o          (w_w),
        .last_issue_o (last_issue),
        .last_nrn_o   (last_nrn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_in_q   <= '0;
            n_out_q  <= '0;
            act_q    <= ACT_LINEAR;
            re_q     <= 1'b0;
            b_re_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= BEAT_NONE;
            y_we_q   <= 1'b0;
            y_addr_q <= '0;
            y_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            y_we_q <= 1'b0;
            beat_q <= BEAT_NONE;
            unique case (state_q)
                IDLE: begin
                    if (run_i) begin
                        if (cfg_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            n_in_q  <= cfg_n_in;
                            n_out_q <= cfg_n_out;
                            act_q   <= cfg_act_sel;
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                            re_q    <= 1'b1;
                            b_re_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Flags lag the read by one cycle to meet the SRAM data.
                    beat_q <= '{start: (i_w == '0),
                                val:   1'b1,
                                last:  last_issue};
                    b_re_q <= 1'b0;
                    if (last_issue) begin
                        re_q    <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.nc_done) begin
                        y_we_q   <= 1'b1;
                        y_addr_q <= j_w;
                        y_data_q <= bus.nc_out;
                        if (last_nrn) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            re_q    <= 1'b1;
                            b_re_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NEURON_LAYER_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (start_run) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    assign bus.x_re   = re_q;
    assign bus.x_addr = i_w;
    assign bus.w_re   = re_q;
    assign bus.w_addr = w_w;
    assign bus.b_re   = b_re_q;
    assign bus.b_addr = j_w;

    assign bus.nc_start    = beat_q.start;
    assign bus.nc_xw_val   = beat_q.val;
    assign bus.nc_xw_last  = beat_q.last;
    assign bus.nc_data     = bus.x_rdata;
    assign bus.nc_weight   = bus.w_rdata;
    assign bus.nc_bias_acc = bus.b_rdata;
    assign bus.nc_act_sel  = act_q;

    assign bus.y_we   = y_we_q;
    assign bus.y_addr = y_addr_q;
    assign bus.y_data = y_data_q;

endmodule
